// File: rtl/bit_serializer_pkg.sv
// Shared types and width helpers for the bit_serializer block.
`timescale 1ns/1ps
package bit_serializer_pkg;

  // FSM states; PAR is only reachable when parity is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Bit counter width: must hold WIDTH-1, never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  // Gap counter width: $clog2(IDLE_GAP+1), kept at least 1 bit so a
  // zero-gap build still has a legal (unused) register.
  function automatic int gap_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial streamer, MSB first, one bit per clock, feeding a
// 1010 sequence detector. Optional even-parity bit per frame is compiled
// in with the BIT_SERIALIZER_PARITY_EN macro; IDLE_GAP inserts idle
// cycles after each frame.
`timescale 1ns/1ps
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int GAP_W = gap_width(IDLE_GAP);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           state;
  // Holds the bits still to be sent, next one at the MSB. The accepted
  // word's MSB goes straight to sout, so the register is loaded pre-shifted.
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_bit;
`endif

  // Ready only in IDLE, and forced low while reset is held.
  assign din_ready = (state == IDLE) & ~rst;
  // Busy decodes straight from the state register.
  assign busy      = (state != IDLE);

  // Single FSM: state, datapath counters and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_done <= 1'b0;
          // din_ready is high whenever we are here and out of reset.
          if (din_valid) begin
            state      <= SHIFT;
            sreg       <= {din[WIDTH-2:0], 1'b0};
            bit_cnt    <= CNT_W'(WIDTH - 1);
            sout       <= din[WIDTH-1];
            sout_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_bit    <= ^din;
`endif
          end
        end

        SHIFT: begin
          if (bit_cnt != '0) begin
            // Present the next bit; it is the LSB when the count hits 1.
            sout       <= sreg[WIDTH-1];
            sreg       <= {sreg[WIDTH-2:0], 1'b0};
            bit_cnt    <= bit_cnt - 1'b1;
            sout_valid <= 1'b1;
            frame_done <= !PAR_EN && (bit_cnt == CNT_W'(1));
          end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
            // LSB just went out; the parity bit closes the frame.
            state      <= PAR;
            sout       <= par_bit;
            sout_valid <= 1'b1;
            frame_done <= 1'b1;
`else
            // LSB just went out; frame over, go idle or into the gap.
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_done <= 1'b0;
            if (IDLE_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(IDLE_GAP - 1);
            end else begin
              state   <= IDLE;
            end
`endif
          end
        end

`ifdef BIT_SERIALIZER_PARITY_EN
        PAR: begin
          // Parity bit just went out; same exit rule as SHIFT.
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_done <= 1'b0;
          if (IDLE_GAP > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(IDLE_GAP - 1);
          end else begin
            state   <= IDLE;
          end
        end
`endif

        GAP: begin
          // Line held at 0 for IDLE_GAP cycles.
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_done <= 1'b0;
          if (gap_cnt == '0) state   <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end

        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
